// File: rtl/s713_resp_misr.sv
// s713_resp_misr: response compactor for the s713 core.
// Folds the 23 s713 primary outputs into a 23-bit MISR (x^23+x^18+1) over
// NPAT accepted vectors. It then compares the signature against a golden
// value and reports pass/fail.
module s713_resp_misr #(
    parameter int unsigned NPAT = 16,          // vectors per run, 1..65535
    parameter logic [22:0] SEED = 23'h000000   // signature start value
) (
    input  logic        CK,
    input  logic        RN,
    input  logic        START,
    input  logic        VALID,
    input  logic [22:0] RESP,
    input  logic [22:0] EXP_SIG,
    output logic        READY,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [22:0] SIG,
    output logic [15:0] COUNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_COMPACT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [22:0] sig_q,   sig_d;
    logic [15:0] count_q, count_d;
    logic        pass_q,  pass_d;

    logic [22:0] misr_nxt;
    logic        last_vec;

    // One MISR step: shift toward MSB, feed back taps 22 and 17 into bit 0,
    // then fold in the response vector.
    always_comb begin
        misr_nxt = {sig_q[21:0], sig_q[22] ^ sig_q[17]} ^ RESP;
    end

    assign last_vec = (count_q == 16'(NPAT - 1));

    // Next-state logic: run sequencing, signature update and golden compare.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so that no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (START) state_d = S_ARM;
            end
            S_ARM: begin
                // VALID is deliberately ignored while arming.
                sig_d   = SEED;
                count_d = '0;
                pass_d  = 1'b0;
                state_d = S_COMPACT;
            end
            S_COMPACT: begin
                if (VALID) begin
                    sig_d   = misr_nxt;
                    count_d = count_q + 16'd1;
                    if (last_vec) begin
                        // Compare against the post-update signature of the last vector.
                        pass_d  = (misr_nxt == EXP_SIG);
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // A restart wins over VALID; that vector is simply dropped.
                if (START) state_d = S_ARM;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CK) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge values.
        if (!RN) begin
            state_q <= S_IDLE;
            sig_q   <= '0;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        READY = (state_q == S_COMPACT);
        BUSY  = (state_q == S_ARM) || (state_q == S_COMPACT);
        DONE  = (state_q == S_DONE);
        PASS  = pass_q && (state_q == S_DONE);
        SIG   = sig_q;
        COUNT = count_q;
    end

endmodule

// File: tb/tb_s713_resp_misr.sv
// Testbench for s713_resp_misr. It uses four instances that share one
// stimulus bus:
//   a: NPAT=1,  SEED=0         single-vector pass
//   b: NPAT=1,  SEED=23'h400000 feedback from bit 22, failing compare
//   c: NPAT=16, SEED=0         sparse VALID, all-zero responses
//   d: NPAT=4,  SEED=23'h420001 table-driven signature, ignore rules, restart, abort
module tb_s713_resp_misr;

    logic        CK = 1'b0;
    logic        RN;
    logic        START;
    logic        VALID;
    logic [22:0] RESP;
    logic [22:0] EXP_SIG;

    logic        a_ready, a_busy, a_done, a_pass;
    logic [22:0] a_sig;
    logic [15:0] a_count;
    logic        b_ready, b_busy, b_done, b_pass;
    logic [22:0] b_sig;
    logic [15:0] b_count;
    logic        c_ready, c_busy, c_done, c_pass;
    logic [22:0] c_sig;
    logic [15:0] c_count;
    logic        d_ready, d_busy, d_done, d_pass;
    logic [22:0] d_sig;
    logic [15:0] d_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CK = ~CK;

    s713_resp_misr #(.NPAT(1), .SEED(23'h000000)) u_a (
        .CK(CK), .RN(RN), .START(START), .VALID(VALID), .RESP(RESP), .EXP_SIG(EXP_SIG),
        .READY(a_ready), .BUSY(a_busy), .DONE(a_done), .PASS(a_pass), .SIG(a_sig), .COUNT(a_count));

    s713_resp_misr #(.NPAT(1), .SEED(23'h400000)) u_b (
        .CK(CK), .RN(RN), .START(START), .VALID(VALID), .RESP(RESP), .EXP_SIG(EXP_SIG),
        .READY(b_ready), .BUSY(b_busy), .DONE(b_done), .PASS(b_pass), .SIG(b_sig), .COUNT(b_count));

    s713_resp_misr #(.NPAT(16), .SEED(23'h000000)) u_c (
        .CK(CK), .RN(RN), .START(START), .VALID(VALID), .RESP(RESP), .EXP_SIG(EXP_SIG),
        .READY(c_ready), .BUSY(c_busy), .DONE(c_done), .PASS(c_pass), .SIG(c_sig), .COUNT(c_count));

    s713_resp_misr #(.NPAT(4), .SEED(23'h420001)) u_d (
        .CK(CK), .RN(RN), .START(START), .VALID(VALID), .RESP(RESP), .EXP_SIG(EXP_SIG),
        .READY(d_ready), .BUSY(d_busy), .DONE(d_done), .PASS(d_pass), .SIG(d_sig), .COUNT(d_count));

    // Vector record for the table-driven part on instance d.
    // The flags field is packed {READY, BUSY, DONE, PASS}.
    typedef struct {
        logic        start;
        logic        valid;
        logic [22:0] resp;
        logic [22:0] exp_in;
        logic [22:0] sig;
        logic [15:0] count;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one rising edge, then settle past it before sampling.
    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic drive(input logic st, input logic vl, input logic [22:0] rs, input logic [22:0] ex);
        START   = st;
        VALID   = vl;
        RESP    = rs;
        EXP_SIG = ex;
    endtask

    task automatic do_reset();
        RN = 1'b0;
        drive(1'b0, 1'b0, 23'h0, 23'h0);
        tick();
        RN = 1'b1;
    endtask

    initial begin
        int model_cnt;
        bit finished;

        // Hand-computed signature chain from SEED=23'h420001.
        vecs[0] = '{1'b0, 1'b1, 23'h000001, 23'h000000, 23'h040003, 16'd1, 4'b1100};
        vecs[1] = '{1'b1, 1'b0, 23'h7FFFFF, 23'h000000, 23'h040003, 16'd1, 4'b1100}; // START ignored, hold
        vecs[2] = '{1'b0, 1'b1, 23'h7FFFFF, 23'h000000, 23'h77FFF9, 16'd2, 4'b1100};
        vecs[3] = '{1'b0, 1'b1, 23'h000100, 23'h000000, 23'h6FFEF2, 16'd3, 4'b1100};
        vecs[4] = '{1'b0, 1'b1, 23'h400000, 23'h1FFDE4, 23'h1FFDE4, 16'd4, 4'b0011}; // last vector, pass
        vecs[5] = '{1'b0, 1'b1, 23'h7FFFFF, 23'h000000, 23'h1FFDE4, 16'd4, 4'b0011}; // DONE holds

        // ---- reset state ----
        RN = 1'b0;
        drive(1'b1, 1'b1, 23'h7FFFFF, 23'h0);
        tick();
        check("rst_flags", {28'h0, d_ready, d_busy, d_done, d_pass}, 32'h0);
        check("rst_sig",   {9'h0, d_sig}, 32'h0);
        check("rst_count", {16'h0, d_count}, 32'h0);
        RN = 1'b1;

        // ---- a: NPAT=1, single vector 1 -> SIG=1, PASS ----
        do_reset();
        drive(1'b1, 1'b0, 23'h0, 23'h0);
        tick();
        check("a_arm_flags", {28'h0, a_ready, a_busy, a_done, a_pass}, 32'h4);
        drive(1'b0, 1'b0, 23'h0, 23'h0);
        tick();
        check("a_compact_flags", {28'h0, a_ready, a_busy, a_done, a_pass}, 32'hC);
        drive(1'b0, 1'b1, 23'h000001, 23'h000001);
        tick();
        drive(1'b0, 1'b0, 23'h0, 23'h0);
        check("a_sig",   {9'h0, a_sig}, 32'h000001);
        check("a_count", {16'h0, a_count}, 32'd1);
        check("a_flags", {28'h0, a_ready, a_busy, a_done, a_pass}, 32'h3);

        // ---- b: SEED bit 22 feeds back into bit 0, EXP=0 fails ----
        do_reset();
        drive(1'b1, 1'b0, 23'h0, 23'h0);
        tick();
        drive(1'b0, 1'b0, 23'h0, 23'h0);
        tick();
        drive(1'b0, 1'b1, 23'h000000, 23'h000000);
        tick();
        drive(1'b0, 1'b0, 23'h0, 23'h0);
        check("b_sig",   {9'h0, b_sig}, 32'h000001);
        check("b_flags", {28'h0, b_ready, b_busy, b_done, b_pass}, 32'h2);
        check("b_count", {16'h0, b_count}, 32'd1);

        // ---- d: VALID during ARM ignored, then table ----
        do_reset();
        drive(1'b1, 1'b0, 23'h0, 23'h0);
        tick();
        check("d_arm_flags", {28'h0, d_ready, d_busy, d_done, d_pass}, 32'h4);
        drive(1'b0, 1'b1, 23'h7FFFFF, 23'h0);
        tick();
        check("d_entry_sig",   {9'h0, d_sig}, 32'h420001);
        check("d_entry_count", {16'h0, d_count}, 32'd0);
        check("d_entry_flags", {28'h0, d_ready, d_busy, d_done, d_pass}, 32'hC);
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].start, vecs[i].valid, vecs[i].resp, vecs[i].exp_in);
            tick();
            check($sformatf("d_vec%0d_sig", i),   {9'h0, d_sig}, {9'h0, vecs[i].sig});
            check($sformatf("d_vec%0d_count", i), {16'h0, d_count}, {16'h0, vecs[i].count});
            check($sformatf("d_vec%0d_flags", i), {28'h0, d_ready, d_busy, d_done, d_pass}, {28'h0, vecs[i].flags});
        end

        // ---- d: START with VALID in DONE -> restart, stray vector dropped ----
        drive(1'b1, 1'b1, 23'h7FFFFF, 23'h0);
        tick();
        check("d_restart_flags", {28'h0, d_ready, d_busy, d_done, d_pass}, 32'h4);
        drive(1'b0, 1'b0, 23'h0, 23'h0);
        tick();
        check("d_restart_sig",   {9'h0, d_sig}, 32'h420001);
        check("d_restart_count", {16'h0, d_count}, 32'd0);
        check("d_restart_flags2", {28'h0, d_ready, d_busy, d_done, d_pass}, 32'hC);

        // ---- d: reset mid-COMPACT aborts, beating START and VALID ----
        drive(1'b0, 1'b1, 23'h000001, 23'h0);
        tick();
        check("d_pre_abort_sig", {9'h0, d_sig}, 32'h040003);
        RN = 1'b0;
        drive(1'b1, 1'b1, 23'h000001, 23'h0);
        tick();
        RN = 1'b1;
        drive(1'b0, 1'b0, 23'h0, 23'h0);
        check("d_abort_sig",   {9'h0, d_sig}, 32'h0);
        check("d_abort_count", {16'h0, d_count}, 32'd0);
        check("d_abort_flags", {28'h0, d_ready, d_busy, d_done, d_pass}, 32'h0);

        // ---- c: NPAT=16, zero responses, random VALID gaps ----
        do_reset();
        drive(1'b1, 1'b0, 23'h0, 23'h0);
        tick();
        drive(1'b0, 1'b0, 23'h0, 23'h0);
        tick();
        model_cnt = 0;
        finished  = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            logic v;
            v = (cyc >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
            drive(1'b0, v, 23'h0, 23'h0);
            tick();
            if (v) model_cnt++;
            check("c_count", {16'h0, c_count}, model_cnt);
            check("c_done",  {31'h0, c_done}, {31'h0, (model_cnt == 16)});
            if (model_cnt == 16) finished = 1'b1;
        end
        drive(1'b0, 1'b0, 23'h0, 23'h0);
        check("c_finished", {31'h0, finished}, 32'd1);
        check("c_sig",   {9'h0, c_sig}, 32'h0);
        check("c_flags", {28'h0, c_ready, c_busy, c_done, c_pass}, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
